// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data cache memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      REST  = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   localparam int MAX_ADDR_W = 64;

   // Clears the byte-within-line bits so the burst starts at word 0 of the line.
   function automatic logic [MAX_ADDR_W-1:0] line_base(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned            line_bytes);
      return addr & ~(MAX_ADDR_W'(line_bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/mem_arbiter_lat_pipe.sv
// Valid shift register that follows outstanding memory reads until their data returns.
module lat_pipe #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld_in,
   output logic vld_out
);

   logic [DEPTH-1:0] pipe_q;
   logic [DEPTH-1:0] pipe_d;

   // Shift a new read marker in at bit 0 every cycle.
   always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = vld_in;
   end

   // Pipe register; reset discards any in-flight reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign vld_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates line bursts from the Icache and Dcache onto one single-port memory.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int MEM_LAT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic [DATA_W-1:0] ic_rdata,
   output logic              ic_rvalid,
   output logic              ic_done,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wready,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_rvalid,
   output logic              dc_done,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int               CNT_W      = $clog2(LINE_WORDS);
   localparam int               LINE_BYTES = LINE_WORDS * 4;
   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(LINE_WORDS - 1);

   arb_state_t        state_q, state_d;
   req_id_t           owner_q, owner_d;
   req_id_t           last_gnt_q, last_gnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;

   logic              grant;
   req_id_t           grant_id;
   logic [ADDR_W-1:0] grant_addr;
   logic              issuing;
   logic              last_issue;
   logic              rd_issue;
   logic              rd_ret;
   logic              line_done;

   assign issuing    = (state_q == ISSUE);
   assign last_issue = issuing && (issue_cnt_q == LAST_WORD);
   assign rd_issue   = issuing && !we_q;
   assign line_done  = rd_ret && (ret_cnt_q == LAST_WORD);

   lat_pipe #(
      .DEPTH (MEM_LAT)
   ) u_lat_pipe (
      .clk     (clk),
      .rst_n   (rst),
      .vld_in  (rd_issue),
      .vld_out (rd_ret)
   );

   // Round-robin pick in IDLE: on a tie the side not granted last wins.
   always_comb begin
      grant      = 1'b0;
      grant_id   = REQ_I;
      grant_addr = ic_addr;
      if (state_q == IDLE) begin
         if (ic_req && dc_req) begin
            grant    = 1'b1;
            grant_id = (last_gnt_q == REQ_I) ? REQ_D : REQ_I;
         end else if (dc_req) begin
            grant    = 1'b1;
            grant_id = REQ_D;
         end else if (ic_req) begin
            grant    = 1'b1;
            grant_id = REQ_I;
         end
      end
      if (grant_id == REQ_D) grant_addr = dc_addr;
   end

   // FSM next state: a write ends in the last issue cycle, a read waits for all returns.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant) state_d = ISSUE;
         ISSUE:   if (last_issue) state_d = we_q ? REST : DRAIN;
         DRAIN:   if (line_done) state_d = REST;
         REST:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Burst bookkeeping: latch owner/direction/line base at grant, advance counters.
   always_comb begin
      owner_d     = owner_q;
      last_gnt_d  = last_gnt_q;
      we_d        = we_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      if (grant) begin
         owner_d     = grant_id;
         last_gnt_d  = grant_id;
         we_d        = (grant_id == REQ_D) && dc_we;
         base_d      = ADDR_W'(line_base(MAX_ADDR_W'(grant_addr), LINE_BYTES));
         issue_cnt_d = '0;
         ret_cnt_d   = '0;
      end
      if (issuing) issue_cnt_d = issue_cnt_q + 1'b1;
      if (rd_ret)  ret_cnt_d   = ret_cnt_q + 1'b1;
   end

   // Control state register with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= REQ_I;
         last_gnt_q  <= REQ_I;
         we_q        <= 1'b0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_gnt_q  <= last_gnt_d;
         we_q        <= we_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
      end
   end

   // Line base is only observed while issuing, so it needs no reset.
   always_ff @(posedge clk) begin
      base_q <= base_d;
   end

   // Outputs decoded from state, owner and counters; read data is gated by its valid.
   always_comb begin
      mem_cs    = issuing;
      mem_we    = issuing && we_q;
      mem_addr  = issuing ? (base_q + (ADDR_W'(issue_cnt_q) << 2)) : '0;
      mem_wdata = (issuing && we_q) ? dc_wdata : '0;
      dc_wready = issuing && we_q;
      ic_rvalid = rd_ret && (owner_q == REQ_I);
      dc_rvalid = rd_ret && (owner_q == REQ_D);
      ic_rdata  = ic_rvalid ? mem_rdata : '0;
      dc_rdata  = dc_rvalid ? mem_rdata : '0;
      ic_done   = line_done && (owner_q == REQ_I);
      dc_done   = (owner_q == REQ_D) && (line_done || (last_issue && we_q));
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables plus reset and hold sequences.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LINE_WORDS = 4;
   localparam int MEM_LAT    = 2;

   localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001;
   localparam logic [31:0] A2 = 32'hA000_0002, A3 = 32'hA000_0003;
   localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD000_0001;
   localparam logic [31:0] D2 = 32'hD000_0002, D3 = 32'hD000_0003;
   localparam logic [31:0] E0 = 32'hE000_0000, E1 = 32'hE000_0001;
   localparam logic [31:0] E2 = 32'hE000_0002, E3 = 32'hE000_0003;

   logic              clk = 1'b0;
   logic              rst;
   logic              ic_req, dc_req, dc_we;
   logic [ADDR_W-1:0] ic_addr, dc_addr;
   logic [DATA_W-1:0] dc_wdata;
   logic [DATA_W-1:0] ic_rdata, dc_rdata, mem_wdata, mem_rdata;
   logic              ic_rvalid, ic_done, dc_rvalid, dc_done, dc_wready;
   logic              mem_cs, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              any_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .MEM_LAT    (MEM_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_rdata  (ic_rdata),
      .ic_rvalid (ic_rvalid),
      .ic_done   (ic_done),
      .dc_req    (dc_req),
      .dc_we     (dc_we),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_wready (dc_wready),
      .dc_rdata  (dc_rdata),
      .dc_rvalid (dc_rvalid),
      .dc_done   (dc_done),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   assign any_out = |{ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done, dc_wready,
                      mem_cs, mem_we, mem_addr, mem_wdata};

   // Memory model: words 0x100..0x10C preloaded with A0..A3, writes tracked per word.
   bit   [31:0] mem     [0:16383];
   bit          wr_flag [0:16383];
   logic [31:0] rd_pipe [MEM_LAT];

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (wr_flag[a[15:2]]) return mem[a[15:2]];
      if (a >= 32'h100 && a <= 32'h10C) return 32'hA000_0000 | {30'd0, a[3:2]};
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (mem_cs && mem_we) begin
         mem[mem_addr[15:2]]     <= mem_wdata;
         wr_flag[mem_addr[15:2]] <= 1'b1;
      end
      rd_pipe[0] <= (mem_cs && !mem_we) ? rd_word(mem_addr) : 32'hDEAD_BEEF;
      for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[MEM_LAT-1];

   typedef struct packed {
      logic        ic_req;
      logic        dc_req;
      logic        dc_we;
      logic [31:0] dc_wdata;
      logic        cs;
      logic        we;
      logic [31:0] addr;
      logic        irv;
      logic [31:0] ird;
      logic        idn;
      logic        drv;
      logic [31:0] drd;
      logic        ddn;
      logic        dwr;
   } vec_t;

   vec_t vecs[$];

   // Row builder: inputs | memory command | Icache return | Dcache return + wready.
   function automatic vec_t mk(input int icr, input int dcr, input int dwe, input logic [31:0] wd,
                               input int cs, input int we, input logic [31:0] ad,
                               input int irv, input logic [31:0] ird, input int idn,
                               input int drv, input logic [31:0] drd, input int ddn, input int dwr);
      vec_t v;
      v.ic_req = (icr != 0); v.dc_req = (dcr != 0); v.dc_we = (dwe != 0); v.dc_wdata = wd;
      v.cs = (cs != 0); v.we = (we != 0); v.addr = ad;
      v.irv = (irv != 0); v.ird = ird; v.idn = (idn != 0);
      v.drv = (drv != 0); v.drd = drd; v.ddn = (ddn != 0); v.dwr = (dwr != 0);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Applies the table one cycle per row, sampling outputs on the falling edge.
   task automatic run_table(input string tn);
      for (int i = 0; i < vecs.size(); i++) begin
         ic_req   = vecs[i].ic_req;
         dc_req   = vecs[i].dc_req;
         dc_we    = vecs[i].dc_we;
         dc_wdata = vecs[i].dc_wdata;
         @(negedge clk);
         chk($sformatf("%s c%0d mem_cs", tn, i),    32'(mem_cs),    32'(vecs[i].cs));
         chk($sformatf("%s c%0d mem_we", tn, i),    32'(mem_we),    32'(vecs[i].we));
         chk($sformatf("%s c%0d mem_addr", tn, i),  mem_addr,       vecs[i].addr);
         chk($sformatf("%s c%0d ic_rvalid", tn, i), 32'(ic_rvalid), 32'(vecs[i].irv));
         chk($sformatf("%s c%0d ic_rdata", tn, i),  ic_rdata,       vecs[i].ird);
         chk($sformatf("%s c%0d ic_done", tn, i),   32'(ic_done),   32'(vecs[i].idn));
         chk($sformatf("%s c%0d dc_rvalid", tn, i), 32'(dc_rvalid), 32'(vecs[i].drv));
         chk($sformatf("%s c%0d dc_rdata", tn, i),  dc_rdata,       vecs[i].drd);
         chk($sformatf("%s c%0d dc_done", tn, i),   32'(dc_done),   32'(vecs[i].ddn));
         chk($sformatf("%s c%0d dc_wready", tn, i), 32'(dc_wready), 32'(vecs[i].dwr));
         @(posedge clk); #1;
      end
      vecs.delete();
   endtask

   // Icache-only read of line 0x100, request dropped the cycle after done.
   task automatic load_ic_read();
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h100,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h104,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h108,  1,A0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h10C,  1,A1,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A2,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A3,1, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
   endtask

   task automatic do_reset();
      rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; dc_wdata = '0;
      @(negedge clk);
      chk("reset outputs zero", 32'(any_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ic_addr = 32'h0000_0104;
      dc_addr = 32'h0000_9004;
      do_reset();

      // Icache read alone.
      load_ic_read();
      run_table("IC_RD");

      // Dcache writeback of D0..D3 to line 0x9000.
      vecs.push_back(mk(1'b0,1,1,0,  0,0,0,        0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,1,1,D0,    1,1,32'h9000, 0,0,0, 0,0,0,1));
      vecs.push_back(mk(0,1,1,D1,    1,1,32'h9004, 0,0,0, 0,0,0,1));
      vecs.push_back(mk(0,1,1,D2,    1,1,32'h9008, 0,0,0, 0,0,0,1));
      vecs.push_back(mk(0,1,1,D3,    1,1,32'h900C, 0,0,0, 0,0,1,1));
      vecs.push_back(mk(0,0,0,0,     0,0,0,        0,0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0,     0,0,0,        0,0,0, 0,0,0,0));
      run_table("DC_WR");
      chk("DC_WR mem 0x9000", mem[14'h2400], D0);
      chk("DC_WR mem 0x9004", mem[14'h2401], D1);
      chk("DC_WR mem 0x9008", mem[14'h2402], D2);
      chk("DC_WR mem 0x900C", mem[14'h2403], D3);

      // Tie with Dcache granted last: Icache wins, then Dcache writes E0..E3.
      vecs.push_back(mk(1,1,1,0,  0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  1,0,32'h100,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  1,0,32'h104,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  1,0,32'h108,  1,A0,0, 0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  1,0,32'h10C,  1,A1,0, 0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  0,0,0,        1,A2,0, 0,0,0,0));
      vecs.push_back(mk(1,1,1,0,  0,0,0,        1,A3,1, 0,0,0,0));
      vecs.push_back(mk(0,1,1,0,  0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,1,1,0,  0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,1,1,E0, 1,1,32'h9000, 0,0,0,  0,0,0,1));
      vecs.push_back(mk(0,1,1,E1, 1,1,32'h9004, 0,0,0,  0,0,0,1));
      vecs.push_back(mk(0,1,1,E2, 1,1,32'h9008, 0,0,0,  0,0,0,1));
      vecs.push_back(mk(0,1,1,E3, 1,1,32'h900C, 0,0,0,  0,0,1,1));
      vecs.push_back(mk(0,0,0,0,  0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0,  0,0,0,        0,0,0,  0,0,0,0));
      run_table("TIE_RR");

      // Dcache read with req dropped in cycle 2: burst still completes.
      vecs.push_back(mk(0,1,0,0, 0,0,0,        0,0,0, 0,0,0,  0));
      vecs.push_back(mk(0,1,0,0, 1,0,32'h9000, 0,0,0, 0,0,0,  0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h9004, 0,0,0, 0,0,0,  0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h9008, 0,0,0, 1,E0,0, 0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h900C, 0,0,0, 1,E1,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0, 1,E2,0, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0, 1,E3,1, 0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0, 0,0,0,  0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0, 0,0,0,  0));
      run_table("DC_DROP");

      // Reset in cycle 3 of an Icache read, then a fresh read.
      ic_req = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      #2;
      chk("RST pre ic_rvalid", 32'(ic_rvalid), 32'd1);
      chk("RST pre ic_rdata", ic_rdata, A0);
      rst = 1'b0;
      #1;
      chk("RST outputs zero", 32'(any_out), 32'd0);
      chk("RST ic_rvalid", 32'(ic_rvalid), 32'd0);
      chk("RST mem_cs", 32'(mem_cs), 32'd0);
      ic_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("RST stale rvalid c%0d", i), 32'({ic_rvalid, dc_rvalid}), 32'd0);
         chk($sformatf("RST idle mem_cs c%0d", i), 32'(mem_cs), 32'd0);
         @(posedge clk); #1;
      end
      load_ic_read();
      run_table("RST_IC_RD");

      // Tie right after reset: Dcache read first, Icache granted in cycle 8.
      do_reset();
      vecs.push_back(mk(1,1,0,0, 0,0,0,        0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,1,0,0, 1,0,32'h9000, 0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,1,0,0, 1,0,32'h9004, 0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,1,0,0, 1,0,32'h9008, 0,0,0,  1,E0,0, 0));
      vecs.push_back(mk(1,1,0,0, 1,0,32'h900C, 0,0,0,  1,E1,0, 0));
      vecs.push_back(mk(1,1,0,0, 0,0,0,        0,0,0,  1,E2,0, 0));
      vecs.push_back(mk(1,1,0,0, 0,0,0,        0,0,0,  1,E3,1, 0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h100,  0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h104,  0,0,0,  0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h108,  1,A0,0, 0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h10C,  1,A1,0, 0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A2,0, 0,0,0,  0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A3,1, 0,0,0,  0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,  0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,  0));
      run_table("TIE_RST");

      // Icache req held through REST: no grant in REST, new burst from the next IDLE.
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h100,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h104,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h108,  1,A0,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 1,0,32'h10C,  1,A1,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A2,0, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        1,A3,1, 0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(1,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h100,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h104,  0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h108,  1,A0,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,0,32'h10C,  1,A1,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        1,A2,0, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        1,A3,1, 0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,0,0,0, 0,0,0,        0,0,0,  0,0,0,0));
      run_table("REST_HOLD");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
